// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, HI/LO forwarding and writes, plus a two-cycle
// multiply-accumulate path for MADD/MADDU/MSUB/MSUBU built only when MADD_MSUB_EN is defined.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mem_whilo_i,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  input  logic        wb_whilo_i,
  input  logic [31:0] wb_hi_i,
  input  logic [31:0] wb_lo_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);
  localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010,
                         SEL_MOVE = 3'b011, SEL_MATH = 3'b100, SEL_MUL = 3'b101;
  localparam logic [7:0] OP_AND  = 8'h24, OP_OR   = 8'h25, OP_XOR  = 8'h26, OP_NOR   = 8'h27,
                         OP_SLL  = 8'h7C, OP_SRL  = 8'h02, OP_SRA  = 8'h03,
                         OP_MOVZ = 8'h0A, OP_MOVN = 8'h0B, OP_MFHI = 8'h10, OP_MTHI = 8'h11,
                         OP_MFLO = 8'h12, OP_MTLO = 8'h13, OP_SLT  = 8'h2A, OP_SLTU  = 8'h2B,
                         OP_ADD  = 8'h20, OP_ADDU = 8'h21, OP_SUB  = 8'h22, OP_SUBU  = 8'h23,
                         OP_ADDI = 8'h55, OP_ADDIU= 8'h56, OP_CLZ  = 8'hB0, OP_CLO   = 8'hB1,
                         OP_MULT = 8'h18, OP_MULTU= 8'h19, OP_MUL  = 8'hA9,
                         OP_MADD = 8'hA6, OP_MADDU= 8'hA8, OP_MSUB = 8'hAA, OP_MSUBU = 8'hAB;

  logic [31:0] hi_eff, lo_eff, sum, diff, wdata, hi, lo;
  logic [63:0] smul, umul;
  logic [5:0]  clz, clo;
  logic        ov, is_madd, wreg, whilo, stall;

  always_comb begin
    if (mem_whilo_i)     {hi_eff, lo_eff} = {mem_hi_i, mem_lo_i};
    else if (wb_whilo_i) {hi_eff, lo_eff} = {wb_hi_i, wb_lo_i};
    else                 {hi_eff, lo_eff} = {hi_i, lo_i};
  end

  assign sum  = reg1_i + reg2_i;
  assign diff = reg1_i - reg2_i;
  assign smul = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
  assign umul = {32'b0, reg1_i} * {32'b0, reg2_i};
  assign is_madd = (aluop_i == OP_MADD) || (aluop_i == OP_MADDU) ||
                   (aluop_i == OP_MSUB) || (aluop_i == OP_MSUBU);

  always_comb begin
    ov = 1'b0;
    if (aluop_i == OP_ADD || aluop_i == OP_ADDI)
      ov = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
    else if (aluop_i == OP_SUB)
      ov = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
  end

  // Highest set bit wins, so the last match in ascending order gives the leading count.
  always_comb begin
    clz = 6'd32;
    clo = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (reg1_i[i])  clz = 6'(31 - i);
      if (!reg1_i[i]) clo = 6'(31 - i);
    end
  end

  always_comb begin
    wdata = '0;
    case (alusel_i)
      SEL_LOGIC: case (aluop_i)
        OP_OR:   wdata = reg1_i | reg2_i;
        OP_AND:  wdata = reg1_i & reg2_i;
        OP_XOR:  wdata = reg1_i ^ reg2_i;
        OP_NOR:  wdata = ~(reg1_i | reg2_i);
        default: wdata = '0;
      endcase
      SEL_SHIFT: case (aluop_i)
        OP_SLL:  wdata = reg2_i << reg1_i[4:0];
        OP_SRL:  wdata = reg2_i >> reg1_i[4:0];
        OP_SRA:  wdata = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
        default: wdata = '0;
      endcase
      SEL_MATH: case (aluop_i)
        OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: wdata = sum;
        OP_SUB, OP_SUBU: wdata = diff;
        OP_SLT:  wdata = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
        OP_SLTU: wdata = {31'b0, reg1_i < reg2_i};
        OP_CLZ:  wdata = {26'b0, clz};
        OP_CLO:  wdata = {26'b0, clo};
        default: wdata = '0;
      endcase
      SEL_MOVE: case (aluop_i)
        OP_MFHI: wdata = hi_eff;
        OP_MFLO: wdata = lo_eff;
        OP_MOVN, OP_MOVZ: wdata = reg1_i;
        default: wdata = '0;
      endcase
      SEL_MUL: wdata = smul[31:0];
      SEL_NOP: wdata = '0;
      default: wdata = '0;
    endcase
  end

`ifdef MADD_MSUB_EN
  localparam logic [0:0] IDLE = 1'b0, ACC = 1'b1;
  logic [0:0]  state_q, state_d;
  logic [63:0] prod_q, prod_d, prod_sel;

  assign prod_sel = (aluop_i == OP_MADD || aluop_i == OP_MSUB) ? smul : umul;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
    end
  end
`else
  logic unused_clk;
  assign unused_clk = clk;
`endif

  always_comb begin
    wreg  = wreg_i & ~ov;
    whilo = 1'b0;
    stall = 1'b0;
    hi    = '0;
    lo    = '0;
    case (aluop_i)
      OP_MTHI:  begin whilo = 1'b1; hi = reg1_i; lo = lo_eff; end
      OP_MTLO:  begin whilo = 1'b1; hi = hi_eff; lo = reg1_i; end
      OP_MULT:  begin whilo = 1'b1; {hi, lo} = smul; end
      OP_MULTU: begin whilo = 1'b1; {hi, lo} = umul; end
      default: ;
    endcase
    if (is_madd) wreg = 1'b0;
`ifdef MADD_MSUB_EN
    state_d = state_q;
    prod_d  = prod_q;
    if (state_q == ACC) begin
      whilo    = 1'b1;
      {hi, lo} = {hi_eff, lo_eff} + prod_q;
      state_d  = IDLE;
    end else if (is_madd) begin
      stall   = 1'b1;
      prod_d  = (aluop_i == OP_MSUB || aluop_i == OP_MSUBU) ? 64'd0 - prod_sel : prod_sel;
      state_d = ACC;
    end
    if (flush_i) state_d = IDLE;
`endif
    if (flush_i) begin
      wreg  = 1'b0;
      whilo = 1'b0;
      stall = 1'b0;
    end
  end

  // Reset gates every output combinationally so they read 0 the moment rst falls.
  assign wd_o       = rst ? wd_i  : '0;
  assign wreg_o     = rst & wreg;
  assign wdata_o    = rst ? wdata : '0;
  assign whilo_o    = rst & whilo;
  assign hi_o       = rst ? hi    : '0;
  assign lo_o       = rst ? lo    : '0;
  assign stallreq_o = rst & stall;
endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; multiply-accumulate steps follow the MADD_MSUB_EN build.
module tb_ex_stage;
  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  aluop_i = '0;
  logic [2:0]  alusel_i = '0;
  logic [31:0] reg1_i = '0, reg2_i = '0, hi_i = '0, lo_i = '0;
  logic [31:0] mem_hi_i = '0, mem_lo_i = '0, wb_hi_i = '0, wb_lo_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0, mem_whilo_i = 1'b0, wb_whilo_i = 1'b0, flush_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .hi_i(hi_i), .lo_i(lo_i), .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i),
    .mem_lo_i(mem_lo_i), .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
    .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [2:0] sel, input logic [7:0] aop,
                    input logic [31:0] a, input logic [31:0] b);
    alusel_i = sel; aluop_i = aop; reg1_i = a; reg2_i = b;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    wd_i = 5'd9; wreg_i = 1'b1; hi_i = 32'h1; lo_i = 32'h5;
    op(3'b100, 8'h21, 32'h1234, 32'h1);
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_whilo", whilo_o, 0);
    chk("rst_hilo", {hi_o, lo_o}, 0);
    chk("rst_stall", stallreq_o, 0);
    step(); rst = 1'b1; #1;

    op(3'b001, 8'h25, 32'hF0F00000, 32'h00000F0F); chk("or", wdata_o, 32'hF0F00F0F);
    chk("wd_pass", wd_o, 5'd9);
    op(3'b001, 8'h24, 32'hFF00FF00, 32'h0FF00FF0); chk("and", wdata_o, 32'h0F000F00);
    op(3'b001, 8'h26, 32'hFF00FF00, 32'h0FF00FF0); chk("xor", wdata_o, 32'hF0F0F0F0);
    op(3'b001, 8'h27, 32'hFF00FF00, 32'h0FF00FF0); chk("nor", wdata_o, 32'h000F000F);
    op(3'b010, 8'h7C, 32'd4, 32'h1);        chk("sll", wdata_o, 32'h10);
    op(3'b010, 8'h02, 32'd4, 32'h80000000); chk("srl", wdata_o, 32'h08000000);
    op(3'b010, 8'h03, 32'd4, 32'h80000000); chk("sra", wdata_o, 32'hF8000000);

    op(3'b100, 8'h20, 32'h7FFFFFFF, 32'h1); chk("add_ov_wreg", wreg_o, 0);
    op(3'b100, 8'h21, 32'h7FFFFFFF, 32'h1); chk("addu_data", wdata_o, 32'h80000000);
    chk("addu_wreg", wreg_o, 1);
    op(3'b100, 8'h55, 32'h80000000, 32'hFFFFFFFF); chk("addi_ov_wreg", wreg_o, 0);
    op(3'b100, 8'h20, 32'h5, 32'hFFFFFFFE); chk("add_ok_data", wdata_o, 32'h3);
    chk("add_ok_wreg", wreg_o, 1);
    op(3'b100, 8'h22, 32'h80000000, 32'h1); chk("sub_ov_wreg", wreg_o, 0);
    op(3'b100, 8'h23, 32'h80000000, 32'h1); chk("subu_data", wdata_o, 32'h7FFFFFFF);
    op(3'b100, 8'h2A, 32'hFFFFFFFF, 32'h1); chk("slt", wdata_o, 1);
    op(3'b100, 8'h2B, 32'hFFFFFFFF, 32'h1); chk("sltu", wdata_o, 0);
    op(3'b100, 8'hB0, 32'h00010000, 0);     chk("clz_15", wdata_o, 15);
    op(3'b100, 8'hB0, 32'h0, 0);            chk("clz_32", wdata_o, 32);
    op(3'b100, 8'hB1, 32'hFFFFFFFF, 0);     chk("clo_32", wdata_o, 32);
    op(3'b100, 8'hB1, 32'hF0000000, 0);     chk("clo_4", wdata_o, 4);

    hi_i = 32'h1; wb_hi_i = 32'h2; mem_hi_i = 32'h3; wb_whilo_i = 1'b1; mem_whilo_i = 1'b1;
    lo_i = 32'h5; wb_lo_i = 32'h6; mem_lo_i = 32'h7;
    op(3'b011, 8'h10, 0, 0); chk("mfhi_mem", wdata_o, 32'h3);
    mem_whilo_i = 1'b0; #1;  chk("mfhi_wb", wdata_o, 32'h2);
    wb_whilo_i = 1'b0; #1;   chk("mfhi_arch", wdata_o, 32'h1);
    op(3'b011, 8'h12, 0, 0); chk("mflo_arch", wdata_o, 32'h5);
    op(3'b011, 8'h0B, 32'hCAFE, 32'h1); chk("movn", wdata_o, 32'hCAFE);
    op(3'b000, 8'h11, 32'hABCD, 0); chk("mthi", {31'b0, whilo_o, hi_o, lo_o}, {32'h1, 32'hABCD, 32'h5});
    wb_whilo_i = 1'b1;
    op(3'b000, 8'h13, 32'hBEEF, 0); chk("mtlo_wb", {31'b0, whilo_o, hi_o, lo_o}, {32'h1, 32'h2, 32'hBEEF});
    wb_whilo_i = 1'b0;
    op(3'b000, 8'h18, 32'hFFFFFFFF, 32'h2); chk("mult", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFE);
    chk("mult_flags", {whilo_o, stallreq_o}, 2'b10);
    op(3'b000, 8'h19, 32'hFFFFFFFF, 32'h2); chk("multu", {hi_o, lo_o}, 64'h00000001_FFFFFFFE);
    op(3'b101, 8'hA9, 32'hFFFFFFFF, 32'h2); chk("mul", wdata_o, 32'hFFFFFFFE);
    chk("mul_whilo", whilo_o, 0);
    op(3'b111, 8'h21, 32'h3, 32'h4);        chk("bad_sel", wdata_o, 0);
    op(3'b100, 8'h21, 32'h3, 32'h4); flush_i = 1'b1; #1;
    chk("flush_wreg", wreg_o, 0);
    flush_i = 1'b0;
    op(3'b000, 8'h18, 32'h3, 32'h4); flush_i = 1'b1; #1;
    chk("flush_whilo", whilo_o, 0);
    flush_i = 1'b0;

    hi_i = 32'h0; lo_i = 32'h5;
`ifdef MADD_MSUB_EN
    op(3'b000, 8'hA6, 32'd3, 32'd4);
    chk("madd_c1", {whilo_o, stallreq_o}, 2'b01);
    step();
    chk("madd_c2_flags", {whilo_o, stallreq_o}, 2'b10);
    chk("madd_c2_hilo", {hi_o, lo_o}, 64'd17);
    op(3'b000, 8'h00, 0, 0); step();
    chk("madd_done", {whilo_o, stallreq_o}, 2'b00);
    lo_i = 32'h3;
    op(3'b000, 8'hAB, 32'd3, 32'd4); step();
    chk("msubu_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF7);
    op(3'b000, 8'h00, 0, 0); step();
    op(3'b000, 8'hA6, 32'd3, 32'd4); step();
    flush_i = 1'b1; #1;
    chk("acc_flush", {whilo_o, stallreq_o}, 2'b00);
    step(); flush_i = 1'b0; #1;
    chk("flush_idle", {whilo_o, stallreq_o}, 2'b01);
    step();
    rst = 1'b0; #1;
    chk("acc_rst", {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o}, 0);
    step(); rst = 1'b1; #1;
    chk("rst_idle", {whilo_o, stallreq_o}, 2'b01);
    op(3'b000, 8'h00, 0, 0); step();
`else
    op(3'b000, 8'hA6, 32'd3, 32'd4);
    chk("madd_off_c1", {wreg_o, whilo_o, stallreq_o}, 3'b000);
    step();
    chk("madd_off_c2", {wreg_o, whilo_o, stallreq_o}, 3'b000);
    op(3'b000, 8'hAB, 32'd3, 32'd4); step();
    chk("msubu_off", {wreg_o, whilo_o, stallreq_o}, 3'b000);
    rst = 1'b0; #1;
    chk("rst_again", {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o}, 0);
    rst = 1'b1;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
